gate_test_sequencer: RTL
========================

Name: gate_test_sequencer

Overview:
Self-test sequencer for the single 2-input logic-gate datapath in the top-level user module. On start it sweeps the gate's inputs through all four truth-table vectors. After a programmable settle time it samples the gate output and compares it with the expected function result. It reports per-vector failures and an overall pass flag on the top-level dedicated outputs.

Parameters:
SETTLE_CYCLES, 2, extra cycles operands are held before sampling c_in (0..15)
NUM_VECTORS, 4, truth-table vectors swept; fixed at 4 for a 2-input gate

Ports:
clk        input   1  system clock
rst_n      input   1  reset; one clock domain, asynchronous assert, active-low (already decided)
ena        input   1  design enable; when 0 the FSM and counters freeze
start      input   1  level-sampled request to begin a sweep
gate_sel   input   2  expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND
c_in       input   1  observed gate output (gate "c")
a_out      output  1  operand a to gate under test
b_out      output  1  operand b to gate under test
busy       output  1  high from the cycle after start is accepted until DONE is left
done       output  1  one-cycle pulse when the sweep completes
pass       output  1  high after a sweep with zero mismatches; held until next accepted start
fail_mask  output  4  bit i set if vector i ({a,b} = i) mismatched
vec_idx    output  2  current vector index

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0; settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: if ena & start → DRIVE. On entry to DRIVE:
  - latch gate_sel into op_q; gate_sel changes mid-sweep are ignored.
  - clear fail_mask and pass; set vec_idx=0; load counter=SETTLE_CYCLES.
- DRIVE: a_out=vec_idx[1], b_out=vec_idx[0].
  - Counter decrements each enabled cycle; at 0 → SAMPLE.
  - DRIVE lasts SETTLE_CYCLES+1 cycles. SETTLE_CYCLES=0 gives one DRIVE cycle.
- SAMPLE, one cycle:
  - If c_in != expected(op_q, a_out, b_out), set fail_mask[vec_idx].
  - If vec_idx==3 → DONE; else vec_idx+1, reload counter, → DRIVE.
  - Operands remain stable through SAMPLE.
- DONE, one cycle: done=1; pass = (fail_mask==0), including the mismatch recorded in the final SAMPLE. Next state IDLE.
- Operand outputs: a_out/b_out return to 0 in IDLE. vec_idx holds 3 until the next start.
- Latency: start accepted at edge k → done high at edge k + 4*(SETTLE_CYCLES+2) + 1 (17 cycles with default).
- busy is high in DRIVE, SAMPLE and DONE.
- start while busy: ignored. start held high through DONE: a new sweep starts from IDLE on the following cycle.
- ena=0 in any state: all registers hold, including the counter. Outputs hold their values; done stays high if frozen in DONE.
- Reset mid-sweep: immediate return to reset values; no partial result is retained.
- Counter width is max(1, $clog2(SETTLE_CYCLES+1)).

Optional Feature:
GATE_SEQ_CONTINUOUS_EN
- Defined: DONE → DRIVE directly, with no start needed, re-sweeping forever.
  - fail_mask becomes sticky and is cleared only by reset.
  - pass updates at each DONE.
  - busy stays high after the first start.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package gate_seq_pkg:
  - gate_op_e enum (AND, OR, XOR, NAND)
  - seq_state_e enum (IDLE, DRIVE, SAMPLE, DONE)
  - localparam NUM_VECTORS = 4
  - function gate_expected(op, a, b)
- Sub-module gate_seq_settle_timer: loadable down-counter with enable, load value and zero flag. Reusable for other datapath sequencers.
- The top-level wrapper connects a_out/b_out to the gate inputs and the gate output to c_in.

Test Plan:
- AND gate, gate_sel=0, SETTLE_CYCLES=2, start pulse → done at cycle 17, pass=1, fail_mask=4'b0000.
- Same gate, gate_sel=1 (expect OR) → vectors 01, 10 mismatch; fail_mask=4'b0110, pass=0.
- c_in forced 1 with gate_sel=3 (NAND) → vector 3 fails; fail_mask=4'b1000, pass=0.
- ena dropped for 5 cycles mid-DRIVE of vector 2 → done delayed exactly 5 cycles; result unchanged.
- rst_n asserted during SAMPLE of vector 1 → all outputs 0 in the same cycle; a fresh start yields a correct full sweep.
- start pulsed while busy and gate_sel toggled mid-sweep → ignored; one done pulse; checks use the original gate_sel.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared types, constants and the gate reference function for the gate test sequencer
package gate_seq_pkg;
  localparam int NUM_VECTORS = 4;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} gate_op_e;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} seq_state_e;
  function automatic logic gate_expected(gate_op_e op, logic a, logic b);
    return op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : ~(a & b);
  endfunction
endpackage

// File: rtl/gate_test_sequencer_if.sv
// gate_seq_if: control, operand and result signals between the sequencer and its user
interface gate_seq_if;
  import gate_seq_pkg::*;
  logic ena;
  logic start;
  logic [1:0] gate_sel;
  logic c_in;
  logic a_out;
  logic b_out;
  logic busy;
  logic done;
  logic pass;
  logic [NUM_VECTORS-1:0] fail_mask;
  logic [1:0] vec_idx;
  modport master(output ena, start, gate_sel, c_in, input a_out, b_out, busy, done, pass, fail_mask, vec_idx);
  modport slave(input ena, start, gate_sel, c_in, output a_out, b_out, busy, done, pass, fail_mask, vec_idx);
endinterface

// File: rtl/gate_seq_settle_timer.sv
// gate_seq_settle_timer: loadable down-counter with enable and zero flag; load wins over decrement
module gate_seq_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (en_i) cnt_q <= load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: sweeps a 2-input gate through its truth table and flags mismatching vectors.
// Define GATE_SEQ_CONTINUOUS_EN to re-sweep forever with a sticky fail_mask.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic    clk,
  input logic    rst_n,
  gate_seq_if.slave bus
);
  localparam int CW = SETTLE_CYCLES < 1 ? 1 : $clog2(SETTLE_CYCLES + 1);
  seq_state_e state_q;
  gate_op_e op_q;
  logic a_q, b_q, busy_q, done_q, pass_q, zero;
  logic [NUM_VECTORS-1:0] mask_q, mask_d;
  logic [1:0] vec_q;
  logic last, load;
  assign last = vec_q == 2'(NUM_VECTORS - 1);
`ifdef GATE_SEQ_CONTINUOUS_EN
  assign load = (state_q == S_IDLE && bus.start) || (state_q == S_SAMPLE && !last) || state_q == S_DONE;
`else
  assign load = (state_q == S_IDLE && bus.start) || (state_q == S_SAMPLE && !last);
`endif
  always_comb begin
    mask_d = mask_q;
    mask_d[vec_q] = mask_q[vec_q] | (bus.c_in != gate_expected(op_q, a_q, b_q));
  end
  gate_seq_settle_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (bus.ena),
    .load_i    (load),
    .load_val_i(CW'(SETTLE_CYCLES)),
    .dec_i     (state_q == S_DRIVE),
    .zero_o    (zero)
  );
  // Operands are registered alongside vec_idx so they stay stable through SAMPLE and DONE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= OP_AND;
      a_q <= 1'b0;
      b_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mask_q <= '0;
      vec_q <= '0;
    end else if (bus.ena) begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q <= S_DRIVE;
          op_q <= gate_op_e'(bus.gate_sel);
`ifndef GATE_SEQ_CONTINUOUS_EN
          mask_q <= '0;
`endif
          pass_q <= 1'b0;
          vec_q <= '0;
          {a_q, b_q} <= 2'b00;
          busy_q <= 1'b1;
        end
        S_DRIVE: if (zero) state_q <= S_SAMPLE;
        S_SAMPLE: begin
          mask_q <= mask_d;
          if (last) begin
            state_q <= S_DONE;
            done_q <= 1'b1;
            pass_q <= mask_d == '0;
          end else begin
            state_q <= S_DRIVE;
            vec_q <= vec_q + 2'd1;
            {a_q, b_q} <= vec_q + 2'd1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
`ifdef GATE_SEQ_CONTINUOUS_EN
          state_q <= S_DRIVE;
          vec_q <= '0;
          {a_q, b_q} <= 2'b00;
`else
          state_q <= S_IDLE;
          busy_q <= 1'b0;
          {a_q, b_q} <= 2'b00;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail_mask = mask_q;
  assign bus.vec_idx = vec_q;
endmodule
